// File: rtl/result_pkt_pkg.sv
// Shared definitions for the result packet collector: packet field layout,
// the decoded packet struct and the collector FSM state type.
package result_pkt_pkg;

   localparam int PKT_W    = 39;
   localparam int TYPE_HI  = 38;
   localparam int TYPE_LO  = 37;
   localparam int RSVD_HI  = 36;
   localparam int RSVD_LO  = 29;
   localparam int ROW_HI   = 28;
   localparam int ROW_LO   = 27;
   localparam int SPIKE_HI = 26;
   localparam int SPIKE_LO = 24;
   localparam int SUM1_HI  = 23;
   localparam int SUM1_LO  = 16;
   localparam int SUM2_HI  = 15;
   localparam int SUM2_LO  = 8;
   localparam int SUM3_HI  = 7;
   localparam int SUM3_LO  = 0;

   localparam logic [1:0] PKT_TYPE_RESULT = 2'b11;
   localparam int         NUM_NEURONS     = 9;

   typedef struct packed {
      logic [1:0] pkt_type;
      logic [7:0] rsvd;
      logic [1:0] row;
      logic [2:0] spike;
      logic [7:0] sum1;
      logic [7:0] sum2;
      logic [7:0] sum3;
   } result_pkt_t;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

   // First residual index of a row (rows are 1-based): (row-1)*3.
   function automatic logic [3:0] row_base(input logic [1:0] row);
      return {2'b00, row - 2'd1} * 4'd3;
   endfunction

endpackage

// File: rtl/result_pkt_unpack.sv
// Combinational decode of a raw result packet into fields plus a validity
// flag (result type and a nonzero row).
module result_pkt_unpack
   import result_pkt_pkg::*;
(
   input  logic [PKT_W-1:0] in_pkt,
   output result_pkt_t      pkt,
   output logic             pkt_ok
);

   assign pkt.pkt_type = in_pkt[TYPE_HI:TYPE_LO];
   assign pkt.rsvd     = in_pkt[RSVD_HI:RSVD_LO];
   assign pkt.row      = in_pkt[ROW_HI:ROW_LO];
   assign pkt.spike    = in_pkt[SPIKE_HI:SPIKE_LO];
   assign pkt.sum1     = in_pkt[SUM1_HI:SUM1_LO];
   assign pkt.sum2     = in_pkt[SUM2_HI:SUM2_LO];
   assign pkt.sum3     = in_pkt[SUM3_HI:SUM3_LO];

   assign pkt_ok = (pkt.pkt_type == PKT_TYPE_RESULT) && (pkt.row != 2'd0);

endmodule

// File: rtl/result_pkt_collector.sv
// Collects three row result packets per timestep into a 9-bit spike map and
// keeps the residual potentials for readback. Optional per-neuron spike
// counters are built when RESULT_SPIKE_COUNT_EN is defined.
module result_pkt_collector
   import result_pkt_pkg::*;
#(
   parameter int WIDTH   = 39,
   parameter int WIDTH_D = 8,
   parameter int NUM_TS  = 10,
   parameter int TS_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_pkt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8:0]         out_spikes,
   output logic [TS_W-1:0]    out_ts,
   input  logic [3:0]         rd_addr,
   output logic [WIDTH_D-1:0] rd_data,
`ifdef RESULT_SPIKE_COUNT_EN
   input  logic [3:0]         cnt_addr,
   output logic [7:0]         cnt_data,
`endif
   output logic               err
);

   localparam logic [TS_W-1:0] TS_LAST = TS_W'(NUM_TS - 1);

   result_pkt_t        pkt_s;
   logic               pkt_ok_s;
   logic [2:0]         row_onehot_s;
   logic [3:0]         base_s;
   logic               handshake_s;
   logic               unused_rsvd_s;

   state_e             state_q, state_d;
   logic [2:0]         row_seen_q, row_seen_d;
   logic [8:0]         spike_map_q, spike_map_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               err_q, err_d;
   logic [WIDTH_D-1:0] resid_q [NUM_NEURONS];
   logic [WIDTH_D-1:0] resid_d [NUM_NEURONS];

   result_pkt_unpack u_unpack (
      .in_pkt (in_pkt),
      .pkt    (pkt_s),
      .pkt_ok (pkt_ok_s)
   );

   assign unused_rsvd_s = ^pkt_s.rsvd;
   assign base_s        = row_base(pkt_s.row);
   assign handshake_s   = (state_q == EMIT) && out_valid_q && out_ready;

   always_comb begin
      case (pkt_s.row)
         2'd1:    row_onehot_s = 3'b001;
         2'd2:    row_onehot_s = 3'b010;
         2'd3:    row_onehot_s = 3'b100;
         default: row_onehot_s = 3'b000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      row_seen_d  = row_seen_q;
      spike_map_d = spike_map_q;
      ts_d        = ts_q;
      resid_d     = resid_q;
      err_d       = 1'b0;
      case (state_q)
         COLLECT: begin
            if (in_valid && in_ready_q) begin
               // Bad or duplicate packets are still consumed, only flagged.
               if (pkt_ok_s && ((row_seen_q & row_onehot_s) == 3'b000)) begin
                  row_seen_d = row_seen_q | row_onehot_s;
                  case (pkt_s.row)
                     2'd1:    spike_map_d[8:6] = pkt_s.spike;
                     2'd2:    spike_map_d[5:3] = pkt_s.spike;
                     2'd3:    spike_map_d[2:0] = pkt_s.spike;
                     default: spike_map_d      = spike_map_q;
                  endcase
                  resid_d[base_s]         = WIDTH_D'(pkt_s.sum1);
                  resid_d[base_s + 4'd1]  = WIDTH_D'(pkt_s.sum2);
                  resid_d[base_s + 4'd2]  = WIDTH_D'(pkt_s.sum3);
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               err_d = 1'b0;
            end
            if (row_seen_d == 3'b111) begin
               state_d = EMIT;
            end else begin
               state_d = COLLECT;
            end
         end
         EMIT: begin
            if (handshake_s) begin
               state_d     = COLLECT;
               row_seen_d  = 3'b000;
               spike_map_d = 9'd0;
               if (ts_q == TS_LAST) begin
                  ts_d = {TS_W{1'b0}};
               end else begin
                  ts_d = ts_q + TS_W'(1);
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: state_d = COLLECT;
      endcase
      in_ready_d  = (state_d == COLLECT);
      out_valid_d = (state_d == EMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         row_seen_q  <= 3'b000;
         spike_map_q <= 9'd0;
         ts_q        <= {TS_W{1'b0}};
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            resid_q[i] <= {WIDTH_D{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         row_seen_q  <= row_seen_d;
         spike_map_q <= spike_map_d;
         ts_q        <= ts_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         resid_q     <= resid_d;
      end
   end

   always_comb begin
      if (rd_addr <= 4'd8) begin
         rd_data = resid_q[rd_addr];
      end else begin
         rd_data = {WIDTH_D{1'b0}};
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_spikes = spike_map_q;
   assign out_ts     = ts_q;
   assign err        = err_q;

`ifdef RESULT_SPIKE_COUNT_EN
   logic [7:0] cnt_q [NUM_NEURONS];
   logic [7:0] cnt_d [NUM_NEURONS];
   logic       wrap_s;

   assign wrap_s = handshake_s && (ts_q == TS_LAST);

   // Neuron n maps to spike-map bit 8-n; clearing on wrap wins over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (wrap_s) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            cnt_d[n] = 8'd0;
         end
      end else if (handshake_s) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            if (spike_map_q[8 - n] && (cnt_q[n] != 8'hFF)) begin
               cnt_d[n] = cnt_q[n] + 8'd1;
            end else begin
               cnt_d[n] = cnt_q[n];
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            cnt_q[n] <= 8'd0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      if (cnt_addr <= 4'd8) begin
         cnt_data = cnt_q[cnt_addr];
      end else begin
         cnt_data = 8'd0;
      end
   end
`endif

endmodule
